load_store_unit: RTL and testbench

// Sits between the CPU execute stage and the shared data bus, directly upstream of the data memory.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and bus control signals of the load/store unit.
// The CPU-side driver uses the master modport and the load/store unit uses slave.
// The bidirectional bus data lines stay a plain inout port on the unit itself.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  data_bus_addr, data_bus_mode
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output data_bus_addr, data_bus_mode
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW request into
// word-wide bus cycles. Sub-word stores use read-modify-write; sub-word loads
// are lane-extracted and extended. Bad requests are faulted without bus activity.
module load_store_unit #(
  parameter logic [31:0] DATA_BASE  = 32'h0000_2000,
  parameter logic [31:0] DATA_LIMIT = 32'h0000_2FFF
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave lsu,
  inout  wire  [31:0]      data_bus_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;

  state_t      state_r;
  logic        store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offset_r;
  logic [15:0] wdata_r;
  logic [31:0] bus_wdata_r;
  logic [31:0] bus_addr_r;
  logic [1:0]  bus_mode_r;
  logic        fault_pend_r;
  logic        resp_valid_r;
  logic        resp_fault_r;
  logic [31:0] resp_rdata_r;

  logic        enc_fault_s;
  logic        window_ok_s;
  logic        req_fault_s;
  logic [31:0] bus_rdata_s;

  // Select the addressed lane of a bus word and sign/zero-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace the target byte/half of the old word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [15:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = old_word;
    case (f3)
      3'b000: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          2'd3:    r[31:24] = wd[7:0];
          default: r = old_word;
        endcase
      end
      3'b001: begin
        if (off[1]) r[31:16] = wd;
        else        r[15:0]  = wd;
      end
      default: r = old_word;
    endcase
    return r;
  endfunction

  // Decode illegal encodings and misalignment of the presented request.
  always_comb begin
    enc_fault_s = 1'b0;
    case (lsu.req_funct3)
      3'b000:          enc_fault_s = 1'b0;
      3'b001:          enc_fault_s = lsu.req_addr[0];
      3'b010:          enc_fault_s = (lsu.req_addr[1:0] != 2'b00);
      3'b100, 3'b101:  enc_fault_s = lsu.req_store;
      default:         enc_fault_s = 1'b1;
    endcase
  end

  assign window_ok_s = (lsu.req_addr >= DATA_BASE) && (lsu.req_addr <= DATA_LIMIT);
  assign req_fault_s = enc_fault_s | ~window_ok_s;
  assign bus_rdata_s = data_bus_data;

  // Request sequencer: owns the bus cycles and the registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      store_r      <= 1'b0;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
      wdata_r      <= 16'h0000;
      bus_wdata_r  <= 32'h0000_0000;
      bus_addr_r   <= 32'h0000_0000;
      bus_mode_r   <= MODE_IDLE;
      fault_pend_r <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      resp_valid_r <= 1'b0;
      fault_pend_r <= 1'b0;
      // A faulted request answers one edge after acceptance, FSM stays idle.
      if (fault_pend_r) begin
        resp_valid_r <= 1'b1;
        resp_fault_r <= 1'b1;
        resp_rdata_r <= 32'h0000_0000;
      end
      case (state_r)
        IDLE: begin
          if (lsu.req_valid) begin
            store_r  <= lsu.req_store;
            funct3_r <= lsu.req_funct3;
            offset_r <= lsu.req_addr[1:0];
            wdata_r  <= lsu.req_wdata[15:0];
            if (req_fault_s) begin
              fault_pend_r <= 1'b1;
            end else begin
              bus_addr_r <= {lsu.req_addr[31:2], 2'b00};
              if (lsu.req_store && (lsu.req_funct3 == 3'b010)) begin
                bus_wdata_r <= lsu.req_wdata;
                bus_mode_r  <= MODE_WR;
                state_r     <= WR;
              end else begin
                bus_mode_r <= MODE_RD;
                state_r    <= RD_ADDR;
              end
            end
          end
        end
        RD_ADDR: begin
          state_r <= RD_DATA;
        end
        RD_DATA: begin
          // Memory output is registered: the read word is valid only now.
          if (store_r) begin
            bus_wdata_r <= merge_store(bus_rdata_s, wdata_r, funct3_r, offset_r);
            bus_mode_r  <= MODE_WR;
            state_r     <= WR;
          end else begin
            resp_valid_r <= 1'b1;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= extract_load(bus_rdata_s, funct3_r, offset_r);
            bus_mode_r   <= MODE_IDLE;
            state_r      <= IDLE;
          end
        end
        WR: begin
          resp_valid_r <= 1'b1;
          resp_fault_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          bus_mode_r   <= MODE_IDLE;
          state_r      <= IDLE;
        end
        default: begin
          bus_mode_r <= MODE_IDLE;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // The bus is driven only while a write cycle is presented.
  assign data_bus_data = (bus_mode_r == MODE_WR) ? bus_wdata_r : 32'bz;

  assign lsu.req_ready     = (state_r == IDLE);
  assign lsu.resp_valid    = resp_valid_r;
  assign lsu.resp_fault    = resp_fault_r;
  assign lsu.resp_rdata    = resp_rdata_r;
  assign lsu.data_bus_addr = bus_addr_r;
  assign lsu.data_bus_mode = bus_mode_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered-output
// word memory on the data bus and a queue of expected responses.
module tb_load_store_unit;

  logic       clk;
  logic       reset;
  wire [31:0] data_bus_data;

  load_store_unit_if bus_if ();

  load_store_unit dut (
    .clk           (clk),
    .reset         (reset),
    .lsu           (bus_if.slave),
    .data_bus_data (data_bus_data)
  );

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  logic [31:0] mem [0:1023];
  logic [31:0] mem_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered read output, write when bus mode is write.
  always @(posedge clk) begin
    mem_q <= mem[bus_if.data_bus_addr[11:2]];
    if (bus_if.data_bus_mode == 2'b10) mem[bus_if.data_bus_addr[11:2]] <= data_bus_data;
  end

  assign data_bus_data = (bus_if.data_bus_mode == 2'b01) ? mem_q : 32'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: drive, push expectation, wait for the response, compare.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic ef, input logic [31:0] er,
                        input int elat, input logic [7:0] emodes);
    exp_t       e;
    int         k;
    logic [7:0] mlog;
    logic       got;
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_store  = st;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = a;
    bus_if.req_wdata  = wd;
    sb_q.push_back({ef, er});
    check({tag, "/ready"}, 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    k = 0;
    mlog = 8'h00;
    got = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      k++;
      mlog = {mlog[5:0], bus_if.data_bus_mode};
      if (bus_if.resp_valid) got = 1'b1;
    end
    check({tag, "/resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      e = sb_q.pop_front();
      check({tag, "/latency"}, 32'(k - 1), 32'(elat));
      check({tag, "/rdata"}, bus_if.resp_rdata, e.rdata);
      check({tag, "/fault"}, 32'(bus_if.resp_fault), 32'(e.fault));
    end
    check({tag, "/modes"}, 32'(mlog), 32'(emodes));
  endtask

  initial begin
    int   k;
    int   nresp;
    int   kresp [3];
    exp_t e;
    logic saw_resp;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_store  = 1'b0;
    bus_if.req_funct3 = 3'b000;
    bus_if.req_addr   = 32'h0000_0000;
    bus_if.req_wdata  = 32'h0000_0000;

    // Reset state
    #12;
    check("rst/mode", 32'(bus_if.data_bus_mode), 32'd0);
    check("rst/addr", bus_if.data_bus_addr, 32'h0000_0000);
    check("rst/resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("rst/rdata", bus_if.resp_rdata, 32'h0000_0000);
    check("rst/fault", 32'(bus_if.resp_fault), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst/ready", 32'(bus_if.req_ready), 32'd1);

    // Word store then load
    do_req("sw_2004", 1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 8'h08);
    do_req("lw_2004", 1'b0, 3'b010, 32'h0000_2004, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 8'h14);

    // Byte store by read-modify-write
    do_req("sw_2008", 1'b1, 3'b010, 32'h0000_2008, 32'h1122_3344, 1'b0, 32'h0, 1, 8'h08);
    do_req("sb_2009", 1'b1, 3'b000, 32'h0000_2009, 32'h0000_00A5, 1'b0, 32'h0, 3, 8'h58);
    do_req("lw_2008", 1'b0, 3'b010, 32'h0000_2008, 32'h0, 1'b0, 32'h1122_A544, 2, 8'h14);

    // Sub-word loads and extension
    do_req("lb_2009", 1'b0, 3'b000, 32'h0000_2009, 32'h0, 1'b0, 32'hFFFF_FFA5, 2, 8'h14);
    do_req("lbu_2009", 1'b0, 3'b100, 32'h0000_2009, 32'h0, 1'b0, 32'h0000_00A5, 2, 8'h14);
    do_req("lh_200a", 1'b0, 3'b001, 32'h0000_200A, 32'h0, 1'b0, 32'h0000_1122, 2, 8'h14);
    do_req("lhu_2008", 1'b0, 3'b101, 32'h0000_2008, 32'h0, 1'b0, 32'h0000_A544, 2, 8'h14);
    do_req("lh_2008", 1'b0, 3'b001, 32'h0000_2008, 32'h0, 1'b0, 32'hFFFF_A544, 2, 8'h14);

    // Upper half store, and the top word of the window
    do_req("sh_2006", 1'b1, 3'b001, 32'h0000_2006, 32'h1234_BEEF, 1'b0, 32'h0, 3, 8'h58);
    do_req("lw_2004b", 1'b0, 3'b010, 32'h0000_2004, 32'h0, 1'b0, 32'hBEEF_BEEF, 2, 8'h14);
    do_req("sw_2ffc", 1'b1, 3'b010, 32'h0000_2FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1, 8'h08);
    do_req("lbu_2fff", 1'b0, 3'b100, 32'h0000_2FFF, 32'h0, 1'b0, 32'h0000_00CA, 2, 8'h14);
    do_req("lb_2fff", 1'b0, 3'b000, 32'h0000_2FFF, 32'h0, 1'b0, 32'hFFFF_FFCA, 2, 8'h14);

    // Faults: never touch the bus, answer at E1
    do_req("flt_lw_2002", 1'b0, 3'b010, 32'h0000_2002, 32'h0, 1'b1, 32'h0, 1, 8'h00);
    do_req("flt_sh_2003", 1'b1, 3'b001, 32'h0000_2003, 32'h0, 1'b1, 32'h0, 1, 8'h00);
    do_req("flt_lb_3000", 1'b0, 3'b000, 32'h0000_3000, 32'h0, 1'b1, 32'h0, 1, 8'h00);
    do_req("flt_f3_011", 1'b0, 3'b011, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 1, 8'h00);
    do_req("flt_st_bu", 1'b1, 3'b100, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 1, 8'h00);
    do_req("flt_lb_1fff", 1'b0, 3'b000, 32'h0000_1FFF, 32'h0, 1'b1, 32'h0, 1, 8'h00);

    // Reset during the read phase of a byte store aborts it
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_store  = 1'b1;
    bus_if.req_funct3 = 3'b000;
    bus_if.req_addr   = 32'h0000_2008;
    bus_if.req_wdata  = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("abort/rd_addr_mode", 32'(bus_if.data_bus_mode), 32'd1);
    @(negedge clk);
    check("abort/rd_data_mode", 32'(bus_if.data_bus_mode), 32'd1);
    reset = 1'b0;
    #1;
    check("abort/mode_now", 32'(bus_if.data_bus_mode), 32'd0);
    check("abort/resp_valid", 32'(bus_if.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) saw_resp = 1'b1;
    end
    check("abort/no_resp", 32'(saw_resp), 32'd0);
    do_req("lw_2008_after", 1'b0, 3'b010, 32'h0000_2008, 32'h0, 1'b0, 32'h1122_A544, 2, 8'h14);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_store  = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr   = 32'h0000_2004;
    sb_q.push_back({1'b0, 32'hBEEF_BEEF});
    sb_q.push_back({1'b0, 32'h1122_A544});
    sb_q.push_back({1'b0, 32'hCAFE_F00D});
    nresp = 0;
    k = 0;
    while (nresp < 3 && k < 20) begin
      @(negedge clk);
      k++;
      if (bus_if.resp_valid) begin
        e = sb_q.pop_front();
        check("b2b/rdata", bus_if.resp_rdata, e.rdata);
        check("b2b/ready", 32'(bus_if.req_ready), 32'd1);
        kresp[nresp] = k;
        nresp++;
        if (nresp == 1) bus_if.req_addr = 32'h0000_2008;
        else if (nresp == 2) bus_if.req_addr = 32'h0000_2FFC;
        else bus_if.req_valid = 1'b0;
      end
    end
    bus_if.req_valid = 1'b0;
    check("b2b/count", 32'(nresp), 32'd3);
    if (nresp == 3) begin
      check("b2b/cyc0", 32'(kresp[0]), 32'd3);
      check("b2b/cyc1", 32'(kresp[1]), 32'd6);
      check("b2b/cyc2", 32'(kresp[2]), 32'd9);
    end
    @(negedge clk);
    @(negedge clk);
    check("b2b/idle_mode", 32'(bus_if.data_bus_mode), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
